// File: rtl/draw_scheduler.sv
// ---------------------------------------------------------------------------
// draw_scheduler
//   Frame-level sequencer and pixel multiplexer between the sprite/target
//   object blocks and the VGA adapter. Once per frame it walks every object
//   through erase-then-redraw using a start/active/done handshake. The
//   selected object's pixel stream is forwarded to the adapter as one
//   registered plot stream, so only one object owns the write port at a time.
//
// Ports
//   CLOCK_50      in   system clock, rising edge
//   reset         in   asynchronous active-high reset
//   obj_done      in   [NUM_OBJ]     object i finished drawing (sits in WAIT)
//   obj_we        in   [NUM_OBJ]     object i write enable
//   obj_x         in   [8*NUM_OBJ]   object i x at [8i+7:8i]
//   obj_y         in   [7*NUM_OBJ]   object i y at [7i+6:7i]
//   obj_colour    in   [24*NUM_OBJ]  object i colour at [24i+23:24i]
//   obj_start     out  [NUM_OBJ]     one-cycle pulse: object erases and reloads
//   obj_active    out  [NUM_OBJ]     level: object may leave LOAD and draw
//   vga_x/y/colour out 8/7/24        registered pixel to the adapter
//   vga_plot      out                registered write enable to the adapter
//   busy          out                a frame pass is in progress
//   overrun       out                sticky: frame tick arrived while busy
//   timeout_err   out                sticky: an object exceeded TIMEOUT
// ---------------------------------------------------------------------------
module draw_scheduler #(
    parameter int NUM_OBJ     = 3,
    parameter int FRAME_TICKS = 833333,
    parameter int TIMEOUT     = 4095
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    input  logic [NUM_OBJ-1:0]      obj_done,
    input  logic [NUM_OBJ-1:0]      obj_we,
    input  logic [8*NUM_OBJ-1:0]    obj_x,
    input  logic [7*NUM_OBJ-1:0]    obj_y,
    input  logic [24*NUM_OBJ-1:0]   obj_colour,
    output logic [NUM_OBJ-1:0]      obj_start,
    output logic [NUM_OBJ-1:0]      obj_active,
    output logic [7:0]              vga_x,
    output logic [6:0]              vga_y,
    output logic [23:0]             vga_colour,
    output logic                    vga_plot,
    output logic                    busy,
    output logic                    overrun,
    output logic                    timeout_err
);

    localparam int SEL_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
    localparam int FC_W  = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(FRAME_TICKS - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_OBJ - 1);
    localparam logic [11:0]      TCNT_MAX = 12'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_START,
        S_ACTIVATE,
        S_DRAW,
        S_NEXT
    } state_t;

    state_t             r_state;
    logic [SEL_W-1:0]   r_sel;
    logic [11:0]        r_tcnt;
    logic [FC_W-1:0]    r_fcnt;
    logic [NUM_OBJ-1:0] r_drawn;
    logic               r_we_prev;

    logic               w_tick;
    logic [NUM_OBJ-1:0] w_sel_oh;
    logic               w_we_sel;
    logic               w_done_sel;
    logic               w_we_rise;
    logic               w_plot_win;
    logic [7:0]         w_x_sel;
    logic [6:0]         w_y_sel;
    logic [23:0]        w_col_sel;

    // Frame counter: free-running, tick on the last count of each frame.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_fcnt <= '0;
        end else if (r_fcnt == FC_LAST) begin
            r_fcnt <= '0;
        end else begin
            r_fcnt <= r_fcnt + 1'b1;
        end
    end

    assign w_tick = (r_fcnt == FC_LAST);

    // Select the current object's signals out of the packed buses.
    always_comb begin
        w_sel_oh  = '0;
        w_x_sel   = '0;
        w_y_sel   = '0;
        w_col_sel = '0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            if (r_sel == SEL_W'(i)) begin
                w_sel_oh[i] = 1'b1;
                w_x_sel     = obj_x[8*i +: 8];
                w_y_sel     = obj_y[7*i +: 7];
                w_col_sel   = obj_colour[24*i +: 24];
            end
        end
    end

    assign w_we_sel   = |(obj_we & w_sel_oh);
    assign w_done_sel = |(obj_done & w_sel_oh);
    // r_we_prev is preset to 1 on ACTIVATE entry, so an erase burst already
    // running in the first cycle is not mistaken for the start of the draw;
    // only a rise after a genuine low counts.
    assign w_we_rise  = w_we_sel & ~r_we_prev;
    assign w_plot_win = (r_state == S_ACTIVATE) || (r_state == S_DRAW);
    assign busy       = (r_state != S_IDLE);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_sel       <= '0;
            r_tcnt      <= '0;
            r_drawn     <= '0;
            r_we_prev   <= 1'b0;
            obj_start   <= '0;
            obj_active  <= '0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            obj_start <= '0;
            // A tick during a pass is dropped, including the NEXT->IDLE cycle.
            if (w_tick && (r_state != S_IDLE)) begin
                overrun <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_tick) begin
                        r_sel   <= '0;
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    // An object never drawn since reset already sits in LOAD.
                    if (r_drawn[r_sel]) begin
                        obj_start <= w_sel_oh;
                        r_state   <= S_START;
                    end else begin
                        obj_active <= w_sel_oh;
                        r_tcnt     <= '0;
                        r_we_prev  <= 1'b1;
                        r_state    <= S_ACTIVATE;
                    end
                end
                S_START: begin
                    obj_active <= w_sel_oh;
                    r_tcnt     <= '0;
                    r_we_prev  <= 1'b1;
                    r_state    <= S_ACTIVATE;
                end
                S_ACTIVATE: begin
                    r_we_prev <= w_we_sel;
                    if (r_tcnt == TCNT_MAX) begin
                        timeout_err    <= 1'b1;
                        r_drawn[r_sel] <= 1'b0;
                        obj_active     <= '0;
                        r_state        <= S_NEXT;
                    end else if (w_we_rise) begin
                        obj_active <= '0;
                        r_tcnt     <= '0;
                        r_state    <= S_DRAW;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                S_DRAW: begin
                    if (r_tcnt == TCNT_MAX) begin
                        timeout_err    <= 1'b1;
                        r_drawn[r_sel] <= 1'b0;
                        obj_active     <= '0;
                        r_state        <= S_NEXT;
                    end else if (w_done_sel) begin
                        r_drawn[r_sel] <= 1'b1;
                        r_state        <= S_NEXT;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                S_NEXT: begin
                    if (r_sel == SEL_LAST) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_sel   <= r_sel + 1'b1;
                        r_state <= S_CHECK;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Pixel path: one register stage, write enable only from the selected
    // object while it owns the port.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
        end else begin
            vga_x      <= w_x_sel;
            vga_y      <= w_y_sel;
            vga_colour <= w_col_sel;
            vga_plot   <= w_we_sel & w_plot_win;
        end
    end

endmodule

// File: tb/tb_draw_scheduler.sv
// ---------------------------------------------------------------------------
// tb_draw_scheduler
//   Drives draw_scheduler with three behavioural object models and checks
//   the forwarded pixel stream through a scoreboard queue, plus per-frame
//   handshake statistics (start pulses, active order, plot counts, sticky
//   flags, timeout latency, asynchronous reset).
// ---------------------------------------------------------------------------
module tb_draw_scheduler;

    localparam int FT  = 5000;
    localparam int TMO = 4095;

    logic         CLOCK_50 = 1'b0;
    logic         reset    = 1'b1;
    logic [2:0]   obj_done;
    logic [2:0]   obj_we;
    logic [23:0]  obj_x;
    logic [20:0]  obj_y;
    logic [71:0]  obj_colour;
    logic [2:0]   obj_start;
    logic [2:0]   obj_active;
    logic [7:0]   vga_x;
    logic [6:0]   vga_y;
    logic [23:0]  vga_colour;
    logic         vga_plot;
    logic         busy;
    logic         overrun;
    logic         timeout_err;

    logic         rogue   = 1'b0;
    logic         nodone1 = 1'b0;
    logic         do_rogue = 1'b0;
    logic [2:0]   m_we;

    int n_tests = 0;
    int n_fail  = 0;

    int f_start [3];
    int f_wide, f_plot, f_len, f_order, f_t1fall, f_tto;

    logic [39:0] sbq [$];

    draw_scheduler #(
        .NUM_OBJ     (3),
        .FRAME_TICKS (FT),
        .TIMEOUT     (TMO)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .obj_done    (obj_done),
        .obj_we      (obj_we),
        .obj_x       (obj_x),
        .obj_y       (obj_y),
        .obj_colour  (obj_colour),
        .obj_start   (obj_start),
        .obj_active  (obj_active),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_colour  (vga_colour),
        .vga_plot    (vga_plot),
        .busy        (busy),
        .overrun     (overrun),
        .timeout_err (timeout_err)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Object models: LOAD -> (active) PRE x3 -> DRAW x1024 -> WAIT(done);
    // start from any state -> ERASE x1025 white -> LOAD.
    typedef enum logic [2:0] {M_LOAD, M_PRE, M_DRAW, M_WAIT, M_ERASE} mst_t;
    mst_t m_st [3];
    int   m_cnt [3];

    always @(posedge CLOCK_50 or posedge reset) begin
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                m_st[i]  <= M_LOAD;
                m_cnt[i] <= 0;
            end else if (obj_start[i]) begin
                m_st[i]  <= M_ERASE;
                m_cnt[i] <= 0;
            end else begin
                case (m_st[i])
                    M_LOAD:  if (obj_active[i]) begin m_st[i] <= M_PRE; m_cnt[i] <= 0; end
                    M_PRE:   if (m_cnt[i] == 2) begin m_st[i] <= M_DRAW; m_cnt[i] <= 0; end
                             else m_cnt[i] <= m_cnt[i] + 1;
                    M_DRAW:  if (m_cnt[i] == 1023) m_st[i] <= M_WAIT;
                             else m_cnt[i] <= m_cnt[i] + 1;
                    M_ERASE: if (m_cnt[i] == 1024) begin m_st[i] <= M_LOAD; m_cnt[i] <= 0; end
                             else m_cnt[i] <= m_cnt[i] + 1;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        m_we       = '0;
        obj_done   = '0;
        obj_x      = '0;
        obj_y      = '0;
        obj_colour = '0;
        for (int i = 0; i < 3; i++) begin
            m_we[i]     = (m_st[i] == M_DRAW) || (m_st[i] == M_ERASE);
            obj_done[i] = (m_st[i] == M_WAIT) && !((i == 1) && nodone1);
            obj_x[8*i +: 8] = 8'(m_cnt[i] + 37 * i);
            obj_y[7*i +: 7] = 7'((m_cnt[i] >> 3) + i);
            obj_colour[24*i +: 24] = (m_st[i] == M_ERASE) ? 24'hFFFFFF
                                                          : {8'(i + 1), 16'(m_cnt[i])};
        end
    end

    // Object 2 can be forced to write out of turn; those writes are never expected.
    assign obj_we = m_we | {rogue, 2'b00};

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Scoreboard: every legitimate model write is expected on vga_* next cycle.
    always @(negedge CLOCK_50) begin : sb
        logic [39:0] e;
        logic [39:0] a;
        if (reset) begin
            sbq.delete();
        end else begin
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                a = {vga_plot, vga_x, vga_y, vga_colour};
                if (e[39] || a[39]) check("pixel", 64'(a), 64'(e));
            end
            e = '0;
            for (int i = 0; i < 3; i++) begin
                if (m_we[i]) e = {1'b1, obj_x[8*i +: 8], obj_y[7*i +: 7], obj_colour[24*i +: 24]};
            end
            sbq.push_back(e);
        end
    end

    function automatic logic pick_bit(input int which);
        return (which == 0) ? busy : obj_active[1];
    endfunction

    task automatic wait_bit(input int which, input logic lvl, input int lim, input string tag);
        int n = 0;
        while (pick_bit(which) !== lvl && n < lim) begin
            @(negedge CLOCK_50);
            n++;
        end
        if (pick_bit(which) !== lvl) check(tag, 64'(pick_bit(which)), 64'(lvl));
    endtask

    // Observe one frame pass from busy rising to busy falling.
    task automatic run_frame();
        logic [2:0] prev_start;
        logic [2:0] prev_act;
        int last_act;
        int idx;
        int rogue_left;
        f_plot = 0; f_wide = 0; f_len = 0; f_order = 0; f_t1fall = -1; f_tto = -1;
        for (int i = 0; i < 3; i++) f_start[i] = 0;
        wait_bit(0, 1'b1, FT + 200, "busy_rise");
        prev_start = '0;
        prev_act   = '0;
        last_act   = -1;
        rogue_left = do_rogue ? 8 : 0;
        while (busy && f_len < 20000) begin
            for (int i = 0; i < 3; i++) begin
                if (obj_start[i] && !prev_start[i]) f_start[i]++;
                if (obj_start[i] && prev_start[i]) f_wide++;
            end
            if (obj_active != 3'b000) begin
                case (obj_active)
                    3'b001:  idx = 0;
                    3'b010:  idx = 1;
                    3'b100:  idx = 2;
                    default: idx = 8;
                endcase
                if (idx != last_act) f_order = f_order * 10 + idx + 1;
                last_act = idx;
            end
            if (prev_act[1] && !obj_active[1] && f_t1fall < 0) f_t1fall = f_len;
            if (timeout_err && f_tto < 0) f_tto = f_len;
            prev_act   = obj_active;
            prev_start = obj_start;
            if (vga_plot) f_plot++;
            if (rogue_left > 0 && obj_active[0]) begin
                rogue = 1'b1;
                rogue_left--;
            end else begin
                rogue = 1'b0;
            end
            f_len++;
            @(negedge CLOCK_50);
        end
        rogue = 1'b0;
        if (busy) check("busy_fall", 64'(busy), 64'(0));
    endtask

    function automatic int start_code();
        return f_start[0] * 100 + f_start[1] * 10 + f_start[2];
    endfunction

    initial begin
        repeat (2) @(negedge CLOCK_50);
        check("rst_start",   64'(obj_start),   64'(0));
        check("rst_active",  64'(obj_active),  64'(0));
        check("rst_plot",    64'(vga_plot),    64'(0));
        check("rst_busy",    64'(busy),        64'(0));
        check("rst_overrun", 64'(overrun),     64'(0));
        check("rst_timeout", 64'(timeout_err), 64'(0));
        check("rst_pixel",   64'({vga_x, vga_y, vga_colour}), 64'(0));
        reset = 1'b0;

        // Frame 1: no erase, objects served in order, rogue writes ignored.
        do_rogue = 1'b1;
        run_frame();
        do_rogue = 1'b0;
        check("f1_starts",  64'(start_code()), 64'(0));
        check("f1_order",   64'(f_order),      64'(123));
        check("f1_plots",   64'(f_plot),       64'(3072));
        check("f1_fits",    64'(f_len < FT),   64'(1));
        check("f1_overrun", 64'(overrun),      64'(0));

        // Frame 2: one start each, erase + draw, pass outlasts the frame.
        run_frame();
        check("f2_starts",  64'(start_code()), 64'(111));
        check("f2_wide",    64'(f_wide),       64'(0));
        check("f2_order",   64'(f_order),      64'(123));
        check("f2_plots",   64'(f_plot),       64'(6147));
        check("f2_overrun", 64'(overrun),      64'(1));
        check("f2_timeout", 64'(timeout_err),  64'(0));

        // Frame 3: asynchronous reset in the middle of object 1's draw.
        wait_bit(0, 1'b1, 2 * FT, "f3_busy");
        wait_bit(1, 1'b1, 12000, "f3_act1_rise");
        wait_bit(1, 1'b0, 12000, "f3_act1_fall");
        repeat (100) @(negedge CLOCK_50);
        check("f3_plot_pre", 64'(vga_plot), 64'(1));
        @(posedge CLOCK_50);
        #2 reset = 1'b1;
        #1;
        check("f3_rst_plot",    64'(vga_plot),    64'(0));
        check("f3_rst_active",  64'(obj_active),  64'(0));
        check("f3_rst_busy",    64'(busy),        64'(0));
        check("f3_rst_overrun", 64'(overrun),     64'(0));
        check("f3_rst_colour",  64'(vga_colour),  64'(0));
        repeat (3) @(negedge CLOCK_50);
        reset   = 1'b0;
        nodone1 = 1'b1;

        // Frame 4: starts skipped after reset, object 1 never finishes.
        run_frame();
        check("f4_starts",  64'(start_code()), 64'(0));
        check("f4_order",   64'(f_order),      64'(123));
        check("f4_plots",   64'(f_plot),       64'(3072));
        check("f4_timeout", 64'(timeout_err),  64'(1));
        check("f4_tmo_lat", 64'(f_tto - f_t1fall), 64'(TMO + 1));

        // Frame 5: timed-out object 1 gets no start.
        run_frame();
        check("f5_starts", 64'(start_code()), 64'(101));
        check("f5_order",  64'(f_order),      64'(123));
        check("f5_plots",  64'(f_plot),       64'(4098));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
